// File: rtl/pdm_capture_ctrl.sv
// Capture sequencer for a PDM microphone: gates M_CLK, waits out mic power-up,
// drops filter-settling samples, then streams PCM words into the sample FIFO.
module pdm_capture_ctrl #(
  parameter int WARMUP_CYCLES   = 1_000_000,
  parameter int DISCARD_SAMPLES = 64,
  parameter int DATA_WIDTH      = 16,
  parameter int COUNT_WIDTH     = 20,
  parameter int MAX_SAMPLES     = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   pcm_valid,
  input  logic [DATA_WIDTH-1:0]  pcm_data,
  input  logic                   fifo_full,
  output logic                   mic_clk_en,
  output logic                   fifo_wr_en,
  output logic [DATA_WIDTH-1:0]  fifo_wr_data,
  output logic [COUNT_WIDTH-1:0] sample_count,
  output logic                   overflow,
  output logic                   done,
  output logic [2:0]             state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WARMUP  = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int DISC_W = (DISCARD_SAMPLES > 1) ? $clog2(DISCARD_SAMPLES) : 1;
  localparam logic [WARM_W-1:0]      WARM_LOAD = WARM_W'(WARMUP_CYCLES - 1);
  localparam logic [DISC_W-1:0]      DISC_LAST = DISC_W'((DISCARD_SAMPLES > 0) ? DISCARD_SAMPLES - 1 : 0);
  localparam logic [COUNT_WIDTH-1:0] MAX_CNT   = COUNT_WIDTH'(MAX_SAMPLES);

  state_t                  state_q, state_d;
  logic [WARM_W-1:0]       warm_cnt_q, warm_cnt_d;
  logic [DISC_W-1:0]       disc_cnt_q, disc_cnt_d;
  logic                    mic_clk_en_d, fifo_wr_en_d, overflow_d, done_d;
  logic [DATA_WIDTH-1:0]   fifo_wr_data_d;
  logic [COUNT_WIDTH-1:0]  sample_count_d, count_inc;

  logic start_ok, accept, write, drop, budget_hit;

  // start is honoured only from IDLE or DONE, and a coincident stop always wins.
  assign start_ok   = start && !stop && (state_q == S_IDLE || state_q == S_DONE);
  assign accept     = (state_q == S_CAPTURE) && pcm_valid && !stop;
  assign write      = accept && !fifo_full;
  assign drop       = accept && fifo_full;
  assign count_inc  = (&sample_count) ? sample_count : sample_count + 1'b1;
  assign budget_hit = (MAX_SAMPLES != 0) && write && (count_inc == MAX_CNT);

  // NOTE: edge-triggered state uses non-blocking (<=) so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start_ok) state_d = S_WARMUP;
      S_WARMUP:  if (stop) state_d = S_IDLE;
                 else if (warm_cnt_q == '0)
                   state_d = (DISCARD_SAMPLES == 0) ? S_CAPTURE : S_SETTLE;
      S_SETTLE:  if (stop) state_d = S_IDLE;
                 else if (pcm_valid && disc_cnt_q == DISC_LAST) state_d = S_CAPTURE;
      S_CAPTURE: if (stop) state_d = S_IDLE;
                 else if (budget_hit) state_d = S_DONE;
      S_DONE:    if (stop) state_d = S_IDLE;
                 else if (start_ok) state_d = S_WARMUP;
      default:   state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; derived from the next state so
  // mic_clk_en and done change on the same edge as the state.
  always_comb begin
    mic_clk_en_d   = (state_d == S_WARMUP) || (state_d == S_SETTLE) || (state_d == S_CAPTURE);
    done_d         = (state_d == S_DONE);
    fifo_wr_en_d   = write;
    fifo_wr_data_d = write ? pcm_data : fifo_wr_data;
    sample_count_d = sample_count;
    overflow_d     = overflow;
    if (start_ok) begin
      sample_count_d = '0;
      overflow_d     = 1'b0;
    end else begin
      if (write) sample_count_d = count_inc;
      if (drop)  overflow_d     = 1'b1;
    end
    warm_cnt_d = (state_q == S_WARMUP && warm_cnt_q != '0) ? warm_cnt_q - 1'b1 : WARM_LOAD;
    disc_cnt_d = '0;
    if (state_q == S_SETTLE) disc_cnt_d = pcm_valid ? disc_cnt_q + 1'b1 : disc_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mic_clk_en   <= 1'b0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      sample_count <= '0;
      overflow     <= 1'b0;
      done         <= 1'b0;
      warm_cnt_q   <= WARM_LOAD;
      disc_cnt_q   <= '0;
    end else begin
      mic_clk_en   <= mic_clk_en_d;
      fifo_wr_en   <= fifo_wr_en_d;
      fifo_wr_data <= fifo_wr_data_d;
      sample_count <= sample_count_d;
      overflow     <= overflow_d;
      done         <= done_d;
      warm_cnt_q   <= warm_cnt_d;
      disc_cnt_q   <= disc_cnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Bench for pdm_capture_ctrl: a budgeted (MAX=4) and an unlimited instance share
// stimulus; a transaction-level model predicts writes and status for both.
module tb_pdm_capture_ctrl;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int DW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, pcm_valid = 1'b0, fifo_full = 1'b0;
  logic [DW-1:0] pcm_data = '0;

  logic          mic_a, wen_a, ovf_a, done_a;
  logic [DW-1:0] wdata_a;
  logic [CW-1:0] cnt_a;
  logic [2:0]    st_a;
  logic          mic_b, wen_b, ovf_b, done_b;
  logic [DW-1:0] wdata_b;
  logic [CW-1:0] cnt_b;
  logic [2:0]    st_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pdm_capture_ctrl #(.WARMUP_CYCLES(W), .DISCARD_SAMPLES(D), .DATA_WIDTH(DW),
                     .COUNT_WIDTH(CW), .MAX_SAMPLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pcm_valid(pcm_valid),
    .pcm_data(pcm_data), .fifo_full(fifo_full), .mic_clk_en(mic_a), .fifo_wr_en(wen_a),
    .fifo_wr_data(wdata_a), .sample_count(cnt_a), .overflow(ovf_a), .done(done_a),
    .state(st_a));

  pdm_capture_ctrl #(.WARMUP_CYCLES(W), .DISCARD_SAMPLES(D), .DATA_WIDTH(DW),
                     .COUNT_WIDTH(CW), .MAX_SAMPLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pcm_valid(pcm_valid),
    .pcm_data(pcm_data), .fifo_full(fifo_full), .mic_clk_en(mic_b), .fifo_wr_en(wen_b),
    .fifo_wr_data(wdata_b), .sample_count(cnt_b), .overflow(ovf_b), .done(done_b),
    .state(st_b));

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 warm-up, 2 settle, 3 capture, 4 done.
  int            m_phase[2], m_warm_left[2], m_disc_left[2], m_cnt[2];
  logic          m_ovf[2], m_wr[2];
  logic [DW-1:0] m_last[2];
  logic [DW-1:0] q_a[$], q_b[$];

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%s] @%0t: got %0h, expected %0h", name, (k == 0) ? "max4" : "unl", $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_warm_left[k] = 0; m_disc_left[k] = 0; m_cnt[k] = 0;
      m_ovf[k] = 1'b0; m_wr[k] = 1'b0; m_last[k] = '0;
    end
    q_a.delete();
    q_b.delete();
  endtask

  task automatic begin_capture(input int k);
    m_phase[k] = 1; m_warm_left[k] = W; m_cnt[k] = 0; m_ovf[k] = 1'b0;
  endtask

  task automatic model_step(input int k);
    int budget;
    budget = (k == 0) ? 4 : 0;
    m_wr[k] = 1'b0;
    if (stop) begin
      m_phase[k] = 0;
    end else begin
      case (m_phase[k])
        0, 4: if (start) begin_capture(k);
        1: begin
          m_warm_left[k]--;
          if (m_warm_left[k] == 0) begin
            m_disc_left[k] = D;
            m_phase[k] = (D > 0) ? 2 : 3;
          end
        end
        2: if (pcm_valid) begin
          m_disc_left[k]--;
          if (m_disc_left[k] == 0) m_phase[k] = 3;
        end
        3: if (pcm_valid) begin
          if (fifo_full) m_ovf[k] = 1'b1;
          else begin
            m_wr[k] = 1'b1;
            m_last[k] = pcm_data;
            if (k == 0) q_a.push_back(pcm_data); else q_b.push_back(pcm_data);
            if (m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
            if (budget != 0 && m_cnt[k] == budget) m_phase[k] = 4;
          end
        end
        default: m_phase[k] = 0;
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  // ---------------- monitor ----------------
  task automatic compare_dut(input int k, input logic [2:0] st, input logic mic, input logic dn,
                             input logic ovf, input logic [CW-1:0] cnt, input logic wen,
                             input logic [DW-1:0] wdata);
    logic [DW-1:0] exp_d;
    check("state", k, 32'(st), 32'(m_phase[k]));
    check("mic_clk_en", k, 32'(mic), 32'(m_phase[k] >= 1 && m_phase[k] <= 3));
    check("done", k, 32'(dn), 32'(m_phase[k] == 4));
    check("overflow", k, 32'(ovf), 32'(m_ovf[k]));
    check("sample_count", k, 32'(cnt), 32'(m_cnt[k]));
    check("fifo_wr_en", k, 32'(wen), 32'(m_wr[k]));
    if (wen) begin
      if ((k == 0) ? (q_a.size() == 0) : (q_b.size() == 0)) begin
        check("unexpected_write", k, 32'(wdata), 32'hFFFF_FFFF);
      end else begin
        exp_d = (k == 0) ? q_a.pop_front() : q_b.pop_front();
        check("fifo_wr_data", k, 32'(wdata), 32'(exp_d));
      end
    end else begin
      check("fifo_wr_data_hold", k, 32'(wdata), 32'(m_last[k]));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      compare_dut(0, st_a, mic_a, done_a, ovf_a, cnt_a, wen_a, wdata_a);
      compare_dut(1, st_b, mic_b, done_b, ovf_b, cnt_b, wen_b, wdata_b);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic s, input logic p, input logic v, input logic [DW-1:0] d);
    start = s; stop = p; pcm_valid = v; pcm_data = d;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; pcm_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, DW'($urandom));
  endtask

  task automatic pulse(input logic [DW-1:0] d, input int gap);
    step(1'b0, 1'b0, 1'b1, d);
    idle(gap);
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_state"}, 0, 32'(st_a), 0);
    check({tag, "_outs"}, 0, {mic_a, wen_a, ovf_a, done_a}, 0);
    check({tag, "_data"}, 0, 32'(wdata_a), 0);
    check({tag, "_count"}, 0, 32'(cnt_a), 0);
    check({tag, "_state"}, 1, 32'(st_b), 0);
    check({tag, "_outs"}, 1, {mic_b, wen_b, ovf_b, done_b}, 0);
    check({tag, "_data"}, 1, 32'(wdata_b), 0);
    check({tag, "_count"}, 1, 32'(cnt_b), 0);
  endtask

  initial begin
    #2;
    outputs_zero("reset");
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal capture: 0x1001/0x1002 discarded, 0x1003.. written.
    step(1'b1, 1'b0, 1'b0, '0);
    idle(W);
    for (int i = 1; i <= 8; i++) pulse(DW'(16'h1000 + i), 4);
    step(1'b0, 1'b1, 1'b0, '0);
    idle(2);

    // start with stop in IDLE stays idle.
    step(1'b1, 1'b1, 1'b0, '0);
    idle(2);

    // start during warm-up is ignored; overflow on one sample, capture continues.
    step(1'b1, 1'b0, 1'b0, '0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, '0);
    idle(W - 4);
    pulse(DW'($urandom), 2);
    pulse(DW'($urandom), 2);
    pulse(DW'($urandom), 1);
    fifo_full = 1'b1;
    pulse(DW'($urandom), 0);
    fifo_full = 1'b0;
    idle(3);
    for (int i = 0; i < 4; i++) pulse(DW'($urandom), $urandom_range(0, 3));

    // start in DONE clears count and overflow.
    idle(2);
    step(1'b1, 1'b0, 1'b0, '0);
    idle(W + 1);
    pulse(DW'($urandom), 1);
    pulse(DW'($urandom), 1);

    // Stop coincident with a sample after two writes.
    pulse(DW'($urandom), 1);
    pulse(DW'($urandom), 1);
    step(1'b0, 1'b1, 1'b1, DW'($urandom));
    idle(3);

    // Back-to-back samples for 10 cycles.
    step(1'b1, 1'b0, 1'b0, '0);
    idle(W);
    pulse(DW'($urandom), 0);
    pulse(DW'($urandom), 0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, DW'($urandom));
    idle(2);
    check("b2b_count", 1, 32'(cnt_b), 10);

    // Reset asserted mid-capture.
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    idle(W);
    pulse(DW'($urandom), 0);
    pulse(DW'($urandom), 0);
    pulse(DW'($urandom), 0);
    #2 rst_n = 1'b0;
    #1;
    outputs_zero("reset_mid");
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Random soak.
    for (int i = 0; i < 3000; i++) begin
      fifo_full = ($urandom_range(0, 7) == 0);
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 2) == 0), DW'($urandom));
    end
    fifo_full = 1'b0;
    idle(3);

    check("queue_drained", 0, 32'(q_a.size()), 0);
    check("queue_drained", 1, 32'(q_b.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdm_capture_ctrl.md
# pdm_capture_ctrl

Capture sequencer between the PDM decimation chain (CIC/FIR → 16-bit PCM) and the sample FIFO read out over SPI. It gates the microphone clock, waits out the microphone power-up interval, discards the first filter-settling samples, then forwards PCM words into the FIFO until stopped or a sample budget is reached. It tracks FIFO overflow and exposes status to the SPI register map.

## Interface
Parameters:
- WARMUP_CYCLES, 1_000_000: sys-clock cycles spent in WARMUP after `mic_clk_en` rises; must be ≥1.
- DISCARD_SAMPLES, 64: `pcm_valid` pulses dropped in SETTLE; 0 skips SETTLE.
- DATA_WIDTH, 16: PCM word width.
- COUNT_WIDTH, 20: width of `sample_count`.
- MAX_SAMPLES, 0: capture budget; 0 means unlimited.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command pulse from the SPI command decoder.
- stop  in  1  one-cycle command pulse.
- pcm_valid  in  1  one-cycle strobe from the decimator.
- pcm_data  in  DATA_WIDTH  PCM sample, valid with `pcm_valid`.
- fifo_full  in  1  FIFO full flag.
- mic_clk_en  out  1  enables the M_CLK generator.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  DATA_WIDTH  FIFO write data.
- sample_count  out  COUNT_WIDTH  samples written in the current capture.
- overflow  out  1  sticky flag: a sample was dropped because the FIFO was full.
- done  out  1  high while in DONE.
- state  out  3  IDLE=0, WARMUP=1, SETTLE=2, CAPTURE=3, DONE=4.

## Operation
- Reset (asynchronous assert) values:
  - state = IDLE.
  - All outputs = 0, including `fifo_wr_data`.
- Registered state machine; all outputs are registered.
- IDLE:
  - `start` → WARMUP.
  - On that transition, clear `sample_count`, `overflow` and `done`; `mic_clk_en` goes to 1.
- WARMUP:
  - `mic_clk_en` = 1.
  - The down-counter loads WARMUP_CYCLES−1 on entry. When it reaches 0, the FSM moves to SETTLE, or to CAPTURE if DISCARD_SAMPLES = 0.
  - `pcm_valid` is ignored.
- SETTLE:
  - Count `pcm_valid` pulses; none are written.
  - The cycle carrying the DISCARD_SAMPLES-th pulse transitions to CAPTURE. That sample is also discarded.
- CAPTURE, on each `pcm_valid`:
  - If `fifo_full` = 0: next cycle `fifo_wr_en` = 1 for exactly one cycle, `fifo_wr_data` = the sampled `pcm_data`, and `sample_count` += 1. `sample_count` saturates at all-ones.
  - If `fifo_full` = 1: the sample is dropped, `overflow` ← 1, and `sample_count` is unchanged.
- End of capture by budget: if MAX_SAMPLES ≠ 0 and a write makes `sample_count` = MAX_SAMPLES, the FSM moves to DONE in the same edge that issues that write.
- DONE:
  - `mic_clk_en` = 0, `done` = 1.
  - `sample_count` and `overflow` are held for SPI readout.
  - `start` → WARMUP (new capture); `stop` → IDLE and clears `done`.
- `stop` in WARMUP, SETTLE or CAPTURE:
  - → IDLE; `mic_clk_en` ← 0.
  - `sample_count` and `overflow` are held.
  - A `pcm_valid` in the same cycle is not written.
- `start` in any state other than IDLE or DONE is ignored.
- `start` and `stop` in the same cycle: `stop` wins; `start` is ignored.
- `fifo_wr_data` holds its last value when `fifo_wr_en` = 0.
- Reset asserted mid-capture returns immediately to reset values. The FIFO is not flushed by this block.

## Timing
- `start` at edge N: state = WARMUP and `mic_clk_en` = 1 after edge N.
- WARMUP lasts exactly WARMUP_CYCLES clock cycles.
- Latency `pcm_valid` → `fifo_wr_en`: 1 cycle. Back-to-back `pcm_valid` (every cycle) is supported with one write per cycle.
- Latency `stop` → `mic_clk_en` low: 1 cycle.
- `overflow` sets 1 cycle after the dropped `pcm_valid`.
- `done` rises 1 cycle after the final write's `pcm_valid`, coincident with that write.

## Test plan
Bench parameters: WARMUP_CYCLES=8, DISCARD_SAMPLES=2, MAX_SAMPLES=4, COUNT_WIDTH=8.
- Reset mid-stream: deassert `rst_n` during CAPTURE → all outputs 0 and state = 0 immediately.
- Normal capture:
  - Stimulus: `start`, then a `pcm_valid` every 5 cycles with data 0x1001, 0x1002, …
  - Required: state = 1 for exactly 8 cycles. 0x1001 and 0x1002 are not written. 0x1003–0x1006 are written, one per `fifo_wr_en`, each 1 cycle after its `pcm_valid`. Then state = 4, `done` = 1, `mic_clk_en` = 0, `sample_count` = 4.
- Overflow:
  - Stimulus: in CAPTURE, hold `fifo_full` = 1 for one `pcm_valid`.
  - Required: no write for that sample, `overflow` = 1, count unchanged. `overflow` stays 1 after `fifo_full` drops; capture continues.
- Stop mid-capture:
  - Stimulus: `stop` coincident with `pcm_valid` after 2 writes.
  - Required: no write, state = 0, `sample_count` = 2, `mic_clk_en` = 0 next cycle.
- Command corners:
  - `start` and `stop` together in IDLE → stays IDLE.
  - `start` during WARMUP → ignored; WARMUP still lasts 8 cycles.
  - `start` in DONE → new capture with `sample_count` and `overflow` cleared.
- Back-to-back samples: with MAX_SAMPLES=0, assert `pcm_valid` every cycle for 10 cycles in CAPTURE → 10 consecutive `fifo_wr_en` cycles with matching data; `sample_count` = 10.
